// File: rtl/present_round_ctrl.sv
// PRESENT-80 encryption core: one full round per clock, valid/ready job handshake.
// The final key whitening is applied combinationally on the registered state in DONE.
module present_round_ctrl #(
    parameter int ROUNDS = 31,
    localparam int size = 64,
    localparam int key_bits = 80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [size-1:0]     plaintext,
    input  logic [key_bits-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [size-1:0]     ciphertext,
    output logic                busy,
    output logic [4:0]          round_idx
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t state, state_next;

    logic [size-1:0]     state_reg;
    logic [key_bits-1:0] key_reg;
    logic [size-1:0]     mixed;
    logic [size-1:0]     subbed;
    logic [size-1:0]     state_round;
    logic [key_bits-1:0] key_rot;
    logic [key_bits-1:0] key_round;
    logic                accept;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (round_idx == 5'(ROUNDS)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;

    // Round function: add round key, S-layer, then bit i moves to 16*i mod 63.
    always_comb begin
        mixed       = state_reg ^ key_reg[79:16];
        subbed      = '0;
        state_round = '0;
        for (int n = 0; n < 16; n++) begin
            subbed[4*n +: 4] = sbox(mixed[4*n +: 4]);
        end
        for (int i = 0; i < 63; i++) begin
            state_round[(16 * i) % 63] = subbed[i];
        end
        state_round[63] = subbed[63];
    end

    always_comb begin
        key_rot             = {key_reg[18:0], key_reg[79:19]};
        key_round           = key_rot;
        key_round[79:76]    = sbox(key_rot[79:76]);
        key_round[19:15]    = key_rot[19:15] ^ round_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            key_reg   <= '0;
            round_idx <= '0;
        end else if (accept) begin
            state_reg <= plaintext;
            key_reg   <= key;
            round_idx <= 5'd1;
        end else if (state == ROUND) begin
            state_reg <= state_round;
            key_reg   <= key_round;
            round_idx <= round_idx + 5'd1;
        end
    end

    // After the last round key_reg already holds K32, so whitening is a plain XOR.
    assign ciphertext = out_valid ? (state_reg ^ key_reg[79:16]) : '0;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl: known PRESENT-80 vectors, stalls, ignored
// requests, mid-job reset, and back-to-back jobs against a software reference.
module tb_present_round_ctrl;

    localparam int ROUNDS = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;
    logic [4:0]  round_idx;

    int checks = 0;
    int errors = 0;

    present_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    always #5 clk = ~clk;

    // Reference PRESENT-80, written as a table lookup and (i%4)*16 + i/4 permutation.
    function automatic logic [63:0] present80_model(input logic [63:0] pt, input logic [79:0] k_in);
        logic [63:0] tbl;
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        tbl = 64'h21748FE3DA09B65C;
        s = pt;
        k = k_in;
        t = '0;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) begin
                t[4*n +: 4] = tbl[4*s[4*n +: 4] +: 4];
            end
            for (int i = 0; i < 64; i++) begin
                s[(i % 4) * 16 + i / 4] = t[i];
            end
            k = {k[18:0], k[79:19]};
            k[79:76] = tbl[4*k[79:76] +: 4];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the accepting edge.
    task automatic start_job(input logic [63:0] pt, input logic [79:0] k, input string tag);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_ready_before_accept: in_ready=%b expected 1", tag, in_ready);
        end
        in_valid  = 1'b1;
        plaintext = pt;
        key       = k;
        step();
        in_valid  = 1'b0;
        plaintext = {$urandom, $urandom};
        key       = {$urandom, $urandom, 16'($urandom)};
    endtask

    // elapsed counts edges since acceptance, the accepting edge being the first.
    task automatic finish_job(input logic [63:0] expected, input int stall, input int elapsed,
                              input string tag);
        int  cycles;
        logic bad;
        cycles = elapsed;
        bad    = 1'b0;
        while (out_valid !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || ciphertext !== 64'h0) bad = 1'b1;
            step();
            cycles++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL %s_running_outputs: busy/in_ready/ciphertext wrong while rounds run", tag);
        end
        checks++;
        if (cycles !== ROUNDS + 1) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", tag, cycles, ROUNDS + 1);
        end
        checks++;
        if (ciphertext !== expected) begin
            errors++;
            $display("[TB] FAIL %s_ciphertext: got %h expected %h", tag, ciphertext, expected);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_done_flags: in_ready=%b busy=%b expected 0 0", tag, in_ready, busy);
        end
        bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            step();
            if (out_valid !== 1'b1 || ciphertext !== expected || in_ready !== 1'b0) bad = 1'b1;
        end
        if (stall > 0) begin
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL %s_hold: result not held for %0d stall cycles, last %h expected %h",
                         tag, stall, ciphertext, expected);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ciphertext !== 64'h0) begin
            errors++;
            $display("[TB] FAIL %s_release: in_ready=%b out_valid=%b ciphertext=%h expected 1 0 0",
                     tag, in_ready, out_valid, ciphertext);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        plaintext = 64'h0123456789ABCDEF;
        key       = 80'h1;
        out_ready = 1'b0;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy_out_valid: got %b %b expected 0 0", busy, out_valid);
        end
        checks++;
        if (round_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_round_idx: got %0d expected 0", round_idx);
        end
        checks++;
        if (ciphertext !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_ciphertext: got %h expected 0", ciphertext);
        end
    endtask

    task automatic test_latency();
        start_job(64'h0, 80'h0, "zero");
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || round_idx !== 5'd1) begin
            errors++;
            $display("[TB] FAIL zero_first_round: busy=%b in_ready=%b round_idx=%0d expected 1 0 1",
                     busy, in_ready, round_idx);
        end
        finish_job(64'h5579C1387B228445, 0, 1, "zero");
    endtask

    task automatic test_vectors();
        start_job(64'h0, 80'hFFFFFFFFFFFFFFFFFFFF, "key_ones");
        finish_job(64'hE72C46C0F5945049, 1, 1, "key_ones");
        start_job(64'hFFFFFFFFFFFFFFFF, 80'h0, "pt_ones");
        finish_job(64'hA112FFC72F68417B, 1, 1, "pt_ones");
    endtask

    task automatic test_stall();
        start_job(64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, "all_ones");
        finish_job(64'h3333DCD3213210D2, 10, 1, "all_ones");
    endtask

    task automatic test_ignore_in_valid();
        start_job(64'h0, 80'h0, "ignore");
        repeat (4) step();
        checks++;
        if (round_idx !== 5'd5) begin
            errors++;
            $display("[TB] FAIL ignore_round_idx: got %0d expected 5", round_idx);
        end
        in_valid  = 1'b1;
        plaintext = 64'hFFFFFFFFFFFFFFFF;
        key       = 80'hFFFFFFFFFFFFFFFFFFFF;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_in_ready: got %b expected 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        finish_job(64'h5579C1387B228445, 2, 6, "ignore");
    endtask

    task automatic test_reset_abort();
        logic seen;
        start_job(64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, "abort");
        repeat (16) step();
        checks++;
        if (round_idx !== 5'd17) begin
            errors++;
            $display("[TB] FAIL abort_round_idx: got %0d expected 17", round_idx);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || round_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL abort_idle: in_ready=%b busy=%b out_valid=%b round_idx=%0d expected 1 0 0 0",
                     in_ready, busy, out_valid, round_idx);
        end
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL abort_no_out_valid: got out_valid pulse or left IDLE expected neither");
        end
        start_job(64'h0, 80'h0, "after_abort");
        finish_job(64'h5579C1387B228445, 0, 1, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [63:0] pt;
        logic [79:0] k;
        logic [63:0] expected;
        for (int j = 0; j < 4; j++) begin
            pt       = {$urandom, $urandom};
            k        = {$urandom, $urandom, 16'($urandom)};
            expected = present80_model(pt, k);
            start_job(pt, k, $sformatf("rand%0d", j));
            finish_job(expected, int'($urandom_range(0, 3)), 1, $sformatf("rand%0d", j));
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        plaintext = '0;
        key       = '0;
        out_ready = 1'b0;
        test_reset();
        test_latency();
        test_vectors();
        test_stall();
        test_ignore_in_valid();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
